// File: rtl/uart_pkg.sv
// Shared UART constants used by the receive path.
package uart_pkg;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned RX_FIFO_WIDTH = UART_BYTE_W;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead byte FIFO between the UART receiver and its consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = RX_FIFO_WIDTH,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           enq_data,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    output logic [WIDTH-1:0]           deq_data,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    ptr_diff;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             enq_fire;
    logic             deq_fire;

    // MSB is the wrap bit: equal low bits with differing MSBs means full.
    always_comb begin
        empty     = (wptr_q == rptr_q);
        full      = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        enq_ready = !full;
        deq_valid = !empty;
        deq_data  = mem[rptr_q[AW-1:0]];
        ptr_diff  = wptr_q - rptr_q;
        count     = CW'(ptr_diff);
    end

    always_comb begin
        enq_fire = enq_valid && enq_ready;
        deq_fire = deq_valid && deq_ready;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        if (enq_fire) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (deq_fire) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is deliberately not reset; contents are only visible once written.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wptr_q[AW-1:0]] <= enq_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: queue model compared every cycle plus directed literal checks.
module tb_uart_rx_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] enq_data;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] model_q[$];

    uart_rx_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enq_data (enq_data),
        .enq_valid(enq_valid),
        .enq_ready(enq_ready),
        .deq_data (deq_data),
        .deq_valid(deq_valid),
        .deq_ready(deq_ready),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: a queue bounded at DEPTH; pushes and pops decided from pre-edge occupancy.
    always @(posedge clk or negedge reset_n) begin : model
        bit do_enq;
        bit do_deq;
        if (!reset_n) begin
            model_q.delete();
        end else begin
            do_enq = enq_valid && (model_q.size() < DEPTH);
            do_deq = deq_ready && (model_q.size() > 0);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back(enq_data);
        end
    end

    always @(negedge clk) begin : compare
        int unsigned sz;
        sz = model_q.size();
        chk("m_count", 32'(count), sz);
        chk("m_empty", 32'(empty), 32'(sz == 0));
        chk("m_full", 32'(full), 32'(sz == DEPTH));
        chk("m_enq_ready", 32'(enq_ready), 32'(sz != DEPTH));
        chk("m_deq_valid", 32'(deq_valid), 32'(sz != 0));
        chk("m_full_and_empty", 32'(full && empty), 0);
        if (sz != 0) chk("m_deq_data", 32'(deq_data), 32'(model_q[0]));
    end

    initial begin
        int sent;
        int got;
        int cyc;

        reset_n   = 1'b0;
        enq_valid = 1'b1;
        enq_data  = 8'hAA;
        deq_ready = 1'b0;

        // Reset held with enq_valid high: nothing may be written.
        repeat (3) step();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_deq_valid", 32'(deq_valid), 0);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        reset_n   = 1'b1;
        enq_valid = 1'b0;
        step();
        chk("rst_nothing_written", 32'(empty), 1);

        // Ordered fill to full, then a held-off 9th byte.
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_data  = 8'(8'h41 + i);
            step();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 8);
        chk("fill_enq_ready", 32'(enq_ready), 0);
        enq_data = 8'h49;
        step();
        chk("fill_held_count", 32'(count), 8);
        chk("fill_head", 32'(deq_data), 32'h41);
        enq_valid = 1'b0;

        // Drain in order.
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(deq_valid), 1);
            chk("drain_data", 32'(deq_data), 32'(8'h41 + i));
            step();
        end
        deq_ready = 1'b0;
        chk("drain_empty", 32'(empty), 1);

        // Full with simultaneous dequeue: no pass-through.
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            enq_data  = 8'(8'h10 + i);
            step();
        end
        enq_data  = 8'h5A;
        deq_ready = 1'b1;
        step();
        chk("full_deq_only_count", 32'(count), 7);
        deq_ready = 1'b0;
        step();
        chk("full_next_enq_count", 32'(count), 8);
        enq_valid = 1'b0;
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("full_drain_data", 32'(deq_data), (i < 7) ? 32'(8'h11 + i) : 32'h5A);
            step();
        end
        chk("full_drain_empty", 32'(empty), 1);

        // Empty with simultaneous enqueue: no fall-through.
        enq_valid = 1'b1;
        enq_data  = 8'h33;
        chk("empty_enq_deq_valid", 32'(deq_valid), 0);
        step();
        enq_valid = 1'b0;
        chk("empty_next_valid", 32'(deq_valid), 1);
        chk("empty_next_data", 32'(deq_data), 32'h33);
        step();
        deq_ready = 1'b0;
        chk("empty_after_take", 32'(empty), 1);

        // Random traffic across pointer wrap; model checks order and occupancy.
        sent = 0;
        got  = 0;
        cyc  = 0;
        while ((sent < 20 || got < 20) && cyc < 400) begin
            enq_valid = (sent < 20) ? 1'($urandom_range(1)) : 1'b0;
            enq_data  = 8'($urandom);
            deq_ready = 1'($urandom_range(1));
            #1;
            if (enq_valid && enq_ready) sent++;
            if (deq_valid && deq_ready) got++;
            step();
            cyc++;
        end
        chk("rand_completed", 32'(got), 20);
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        step();
        chk("rand_empty", 32'(empty), 1);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            enq_valid = 1'b1;
            enq_data  = 8'(8'hC0 + i);
            step();
        end
        enq_valid = 1'b0;
        chk("arst_pre_count", 32'(count), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        step();
        reset_n = 1'b1;
        step();
        enq_valid = 1'b1;
        enq_data  = 8'h7E;
        step();
        enq_valid = 1'b0;
        chk("arst_first_valid", 32'(deq_valid), 1);
        chk("arst_first_data", 32'(deq_data), 32'h7E);
        chk("arst_first_count", 32'(count), 1);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
